// File: rtl/sr_arb_pkg.sv
// rtl/sr_arb_pkg.sv - shared constants and state encoding for the mutex arbiter
package sr_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANTED  = 2'b01,
    COOLDOWN = 2'b10
  } state_e;

  // Index width that stays legal for any requester count.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_mutex_arbiter_if.sv
// rtl/sr_mutex_arbiter_if.sv - request/release/grant bundle between requesters and the arbiter
interface sr_mutex_arbiter_if #(
  parameter int N_REQ = sr_arb_pkg::N_REQ_DEF
);
  import sr_arb_pkg::*;

  localparam int OW = idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] grant;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req, rel,
    input  grant, owner, busy, timeout_err
  );

  modport slave (
    input  req, rel,
    output grant, owner, busy, timeout_err
  );

endinterface

// File: rtl/sr_flag_cell.sv
// rtl/sr_flag_cell.sv - registered set/reset flag, reset dominant over set
module sr_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (r) begin
      q_d = 1'b0;
    end else if (s) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/sr_mutex_arbiter.sv
// rtl/sr_mutex_arbiter.sv - round-robin mutex arbiter with hold timeout and one-cycle cooldown
module sr_mutex_arbiter
  import sr_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sr_mutex_arbiter_if.slave  bus
);

  localparam int OW = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  logic [OW-1:0]    pick;
  logic             any_req;
  logic             rel_own;
  logic             hold_done;
  logic             release_now;
  logic             flag_s, flag_r;
  logic             busy_q, busy_n;

  // Round-robin search: candidates walk upward from the slot after the last owner.
  always_comb begin
    logic [OW-1:0] cand;
    cand    = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = OW'((int'(last_owner_q) + k) % N_REQ);
      if (!any_req && bus.req[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  assign rel_own     = bus.rel[owner_q];
  assign hold_done   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign release_now = (state_q == GRANTED) && (rel_own || hold_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      cnt_q        <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_req) state_d = GRANTED;
      GRANTED:  if (release_now) state_d = COOLDOWN;
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    terr_d       = 1'b0;
    flag_s       = 1'b0;
    flag_r       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          owner_d      = pick;
          last_owner_d = pick;
          cnt_d        = '0;
          flag_s       = busy_n;
        end
      end
      GRANTED: begin
        if (release_now) begin
          // An owner release landing on the last allowed cycle is a normal release.
          grant_d = '0;
          owner_d = '0;
          cnt_d   = '0;
          terr_d  = !rel_own;
          flag_r  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  sr_flag_cell u_busy (
    .clk   (clk),
    .rst   (rst),
    .s     (flag_s),
    .r     (flag_r),
    .q     (busy_q),
    .q_bar (busy_n)
  );

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sr_mutex_arbiter.sv
// tb/tb_sr_mutex_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_sr_mutex_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_mutex_arbiter_if #(.N_REQ(N)) bus ();

  sr_mutex_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner, m_held, m_dead, m_last;
  bit m_terr;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] g;
    int         o;
    logic       b;
    logic       t;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] l);
    rst     = r;
    bus.req = q;
    bus.rel = l;
  endtask

  // Ownership as an integer plus a dead-cycle countdown after every release.
  task automatic model_step();
    bit found;
    int c;
    if (rst) begin
      m_owner = -1; m_held = 0; m_dead = 0; m_last = N - 1; m_terr = 0;
    end else begin
      m_terr = 0;
      if (m_owner >= 0) begin
        if (bus.rel[m_owner] || m_held == TO) begin
          m_terr  = !bus.rel[m_owner];
          m_owner = -1;
          m_dead  = 1;
        end else begin
          m_held++;
        end
      end else if (m_dead > 0) begin
        m_dead--;
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && bus.req[c]) begin
            found = 1; m_owner = c; m_last = c; m_held = 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("no_s_and_r", int'(dut.flag_s & dut.flag_r), 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_grant", bus.grant, (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("model_owner", bus.owner, (m_owner >= 0) ? m_owner : 0);
    chk("model_busy", bus.busy, (m_owner >= 0) ? 1 : 0);
    chk("model_terr", bus.timeout_err, m_terr);
    chk("onehot", ($countones(bus.grant) <= 1) ? 1 : 0, 1);
    chk("busy_eq_or_grant", bus.busy, |bus.grant);
  endtask

  initial begin
    int gap, held, exp_o;
    bit done;

    drive(1'b1, 4'b0, 4'b0);
    m_owner = -1; m_held = 0; m_dead = 0; m_last = N - 1; m_terr = 0;

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0101, 4'b0000, 4'b0001, 0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0101, 4'b0100, 4'b0001, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0101, 4'b0001, 4'b0000, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0010, 4'b0100, 2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b0110, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'b0110, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].rel);
      tick();
      chk($sformatf("vec%0d_grant", i), bus.grant, vecs[i].g);
      chk($sformatf("vec%0d_owner", i), bus.owner, vecs[i].o);
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].b);
      chk($sformatf("vec%0d_terr", i), bus.timeout_err, vecs[i].t);
    end

    // Round-robin rotation with all requesters active, 3-cycle holds.
    drive(1'b1, 4'b0, 4'b0); tick();
    drive(1'b0, 4'hF, 4'b0); tick();
    for (int i = 0; i < 5; i++) begin
      exp_o = i % N;
      chk("rr_owner", bus.owner, exp_o);
      chk("rr_grant", bus.grant, 1 << exp_o);
      tick(); tick();
      bus.rel = 4'(1 << exp_o);
      tick();
      bus.rel = 4'b0;
      gap = 0;
      while (bus.grant == 4'b0 && gap < 8) begin
        gap++;
        tick();
      end
      chk("rr_gap", gap, 2);
    end

    // Owner 1 never releases: forced release after TO cycles, then 3 wins.
    drive(1'b1, 4'b0, 4'b0); tick();
    drive(1'b0, 4'b0010, 4'b0); tick();
    chk("to_owner", bus.owner, 1);
    bus.req = 4'b1011;
    held = 1; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (bus.grant == 4'b0010) held++;
      else done = 1;
    end
    chk("to_hold_cycles", held, TO);
    chk("to_terr_pulse", bus.timeout_err, 1);
    chk("to_grant_dropped", bus.grant, 0);
    tick();
    chk("to_terr_clear", bus.timeout_err, 0);
    tick();
    chk("to_next_grant", bus.grant, 4'b1000);
    chk("to_next_owner", bus.owner, 3);

    // Release on the final allowed cycle is a normal release.
    drive(1'b1, 4'b0, 4'b0); tick();
    drive(1'b0, 4'b0100, 4'b0); tick();
    for (int c = 0; c < TO - 1; c++) tick();
    chk("edge_still_granted", bus.grant, 4'b0100);
    bus.rel = 4'b0100;
    tick();
    bus.rel = 4'b0;
    chk("edge_grant", bus.grant, 0);
    chk("edge_terr", bus.timeout_err, 0);
    tick();
    chk("edge_terr_after", bus.timeout_err, 0);

    // Reset while owner 3 holds the resource.
    drive(1'b1, 4'b0, 4'b0); tick();
    drive(1'b0, 4'b1000, 4'b0); tick();
    chk("rst_owner3", bus.owner, 3);
    drive(1'b1, 4'b1001, 4'b0); tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_terr", bus.timeout_err, 0);
    drive(1'b0, 4'b1001, 4'b0); tick();
    chk("rst_req0_wins", bus.grant, 4'b0001);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      bus.req = 4'($urandom_range(0, 15));
      bus.rel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      if (m_owner >= 0 && $urandom_range(0, 19) == 0) bus.rel[m_owner] = 1'b1;
      if (m_owner >= 0 && $urandom_range(0, 1) == 0) bus.rel[m_owner] = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_mutex_arbiter.md
SR_MUTEX_ARBITER -- requirements
Module: sr_mutex_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16: maximum consecutive GRANTED cycles before a forced release (2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester level request for the shared resource.
REQ-006 rel  input  N_REQ  per-requester one-cycle release strobe.
REQ-007 grant  output  N_REQ  one-hot registered grant; all-zero when no owner.
REQ-008 owner  output  clog2(N_REQ)  index of current owner; valid only while busy=1, 0 otherwise.
REQ-009 busy  output  1  resource-held flag, driven directly from q of the SR flag cell.
REQ-010 timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-011 FSM states: IDLE (no owner), GRANTED (one owner), COOLDOWN (one dead cycle after any release).
REQ-012 IDLE: when any req bit is 1 at edge t, the block SHALL enter GRANTED with grant, owner and busy valid at t+1; with no req, it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: search starts at last_owner+1 modulo N_REQ, and the first set req bit wins.
REQ-014 last_owner SHALL update only when a grant is issued.
REQ-015 GRANTED: rel[owner]=1 at edge t SHALL give grant=0 and busy=0 at t+1 (COOLDOWN), IDLE at t+2, and the earliest new grant at t+3.
REQ-016 rel bits from non-owners, and any rel while in IDLE or COOLDOWN, SHALL be ignored.
REQ-017 Owner dropping req while GRANTED SHALL be ignored; only rel or timeout ends ownership.
REQ-018 Hold counter SHALL clear on entry to GRANTED and increment each GRANTED cycle.
REQ-019 Forced release: when the hold counter equals TIMEOUT-1 with no rel[owner], the block SHALL perform the REQ-015 release and pulse timeout_err for exactly the COOLDOWN cycle.
REQ-020 If rel[owner] arrives in the same cycle the counter reaches TIMEOUT-1, the release is normal and timeout_err SHALL stay 0.
REQ-021 If req[i] and rel[i] are both 1 for the owner in the same cycle, release SHALL win; round-robin then makes i lowest priority.
REQ-022 Flag-cell drive: s=1 only on the IDLE->GRANTED edge, r=1 only on the GRANTED->COOLDOWN edge, s=r=0 otherwise; s=r=1 SHALL never occur.
REQ-023 Invariant: busy == (state==GRANTED) == |grant, every cycle.
REQ-024 grant SHALL never have more than one bit set.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, grant=0, owner=0, busy=0 (flag cell cleared), timeout_err=0, counter=0, and last_owner=N_REQ-1, so requester 0 has highest priority.
REQ-026 Reset mid-GRANTED SHALL deassert grant the next cycle with no timeout_err and no COOLDOWN cycle.
REQ-027 rst SHALL dominate req, rel and timeout in the same cycle.

Structure
REQ-028 Shared package sr_arb_pkg SHALL hold the state encoding (IDLE=2'b00, GRANTED=2'b01, COOLDOWN=2'b10), default N_REQ and TIMEOUT, and the counter width constant (8).
REQ-029 One sub-module, sr_flag_cell (ports s, r, clk, rst, q, q_bar; synchronous active-high reset to q=0; r dominant), SHALL hold the busy flag.
REQ-030 Arbitration SHALL be combinational feeding registered grant and owner outputs; no other sub-modules are permitted.

Verification
REQ-031 Reset then req=4'b0101 -> grant=4'b0001, owner=0, busy=1 one cycle later; rel=4'b0001 -> COOLDOWN, IDLE, then grant=4'b0100, owner=2.
REQ-032 req=4'b1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0 with a 2-cycle gap (grant=0) between grants.
REQ-033 Owner 1 granted and never releases, TIMEOUT=16 -> grant drops after 16 GRANTED cycles, timeout_err=1 for exactly one cycle, and the next pending requester is granted.
REQ-034 rel=4'b0100 while owner=1, and rel during IDLE -> no state, grant or busy change.
REQ-035 rst=1 while owner=3 is GRANTED -> next cycle grant=0, busy=0, timeout_err=0; with req=4'b1001 afterwards, requester 0 wins.
REQ-036 All scenarios: assert one-hot grant, busy==|grant, and no s=r=1 on the flag cell every cycle.
